// File: rtl/bus_if_types_pkg.sv
// Shared bus types for the peripheral fabric: transfer type, arbiter
// state encoding and the read data returned on a watchdog completion.
package bus_if_types_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Master-side and slave-side signals around the shared-bus arbiter.
// The slave modport is the face the arbiter shows to the bus masters;
// the master modport is the face it shows to the downstream decoder.
interface bus_rr_arbiter_if
  import bus_if_types_pkg::*;
#(
  parameter int N_MASTERS = 2
) ();

  // requesting masters
  logic [N_MASTERS-1:0] m_req;
  ttype_t               m_ttype [N_MASTERS];
  logic [31:0]          m_addr  [N_MASTERS];
  logic [31:0]          m_wdata [N_MASTERS];
  logic [31:0]          m_rdata;
  logic [N_MASTERS-1:0] m_done;
  logic                 m_err;

  // downstream slave port
  logic        s_ss;
  ttype_t      s_ttype;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic        s_bdone;

  modport slave (
    input  m_req, m_ttype, m_addr, m_wdata,
    output m_rdata, m_done, m_err
  );

  modport master (
    output s_ss, s_ttype, s_addr, s_wdata,
    input  s_rdata, s_bdone
  );

endinterface

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after 'last', wrapping
// modulo N. Purely combinational so it can be reused by other priority logic.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);

  localparam int W = $clog2(N);

  // scan last+1, last+2, ... last+N and keep the first hit
  always_comb begin
    logic [W-1:0] cand;
    logic         found;
    any   = |req;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = W'((int'(last) + k) % N);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one slave port between N bus masters, with a
// watchdog that forces an error completion when the slave never answers.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no transfer in flight; round-robin re-evaluated this cycle
//   BUSY  | grant_id owns the slave port until s_bdone or watchdog expiry
module bus_rr_arbiter
  import bus_if_types_pkg::*;
#(
  parameter int          N_MASTERS = 2,
  parameter int          TIMEOUT   = 64,
  parameter logic [31:0] ERR_DATA  = BUS_ERR_DATA
) (
  input  logic                         clk,
  input  logic                         rst_n,
  bus_rr_arbiter_if.slave              up,
  bus_rr_arbiter_if.master             dn,
  output logic [$clog2(N_MASTERS)-1:0] grant_id
);

  localparam int            GW       = $clog2(N_MASTERS);
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  arb_state_t state_q, state_d;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] last_q;
  logic [TW-1:0] timer_q;
  // Downstream fields stay zero until the first grant after reset.
  logic          granted_q;

  logic          pick_any;
  logic [GW-1:0] pick_idx;
  logic          bdone_hit;
  logic          tmo_hit;
  logic          fin;

  ttype_t               sel_ttype;
  logic [31:0]          sel_addr;
  logic [31:0]          sel_wdata;
  logic                 sel_ss;
  logic [N_MASTERS-1:0] done_vec;
  logic                 err_flag;
  logic [31:0]          rdata_mux;

  rr_pick #(
    .N (N_MASTERS)
  ) u_pick (
    .req  (up.m_req),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // A slave answer in the final watchdog cycle still counts as a normal completion.
  assign bdone_hit = (state_q == BUSY) && dn.s_bdone;
  assign tmo_hit   = (state_q == BUSY) && !dn.s_bdone && (timer_q == TMO_LAST);
  assign fin       = bdone_hit || tmo_hit;

  // state register, grant bookkeeping and the BUSY watchdog timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= GW'(N_MASTERS - 1);
      timer_q   <= '0;
      granted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (pick_any) begin
          grant_q   <= pick_idx;
          timer_q   <= '0;
          granted_q <= 1'b1;
        end
      end else if (fin) begin
        last_q <= grant_q;
      end else begin
        timer_q <= timer_q + TW'(1);
      end
    end
  end

  // next state: one arbitration cycle in IDLE, hold BUSY until completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = BUSY;
      BUSY:    if (fin)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs: mux the granted master downstream and steer the completion back
  always_comb begin
    sel_ss    = 1'b0;
    sel_ttype = READ;
    sel_addr  = '0;
    sel_wdata = '0;
    done_vec  = '0;
    err_flag  = 1'b0;
    rdata_mux = '0;
    if (granted_q) begin
      sel_ttype = up.m_ttype[grant_q];
      sel_addr  = up.m_addr[grant_q];
      sel_wdata = up.m_wdata[grant_q];
    end
    if (state_q == BUSY) sel_ss = 1'b1;
    if (fin) done_vec[grant_q] = 1'b1;
    if (bdone_hit) begin
      rdata_mux = dn.s_rdata;
    end else if (tmo_hit) begin
      rdata_mux = ERR_DATA;
      err_flag  = 1'b1;
    end
  end

  assign dn.s_ss    = sel_ss;
  assign dn.s_ttype = sel_ttype;
  assign dn.s_addr  = sel_addr;
  assign dn.s_wdata = sel_wdata;
  assign up.m_done  = done_vec;
  assign up.m_err   = err_flag;
  assign up.m_rdata = rdata_mux;
  assign grant_id   = grant_q;

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Shares one slave bus port, e.g. the GPIO peripheral or a peripheral segment, between N_MASTERS bus masters (CPU data port, debug module, DMA).
- Round-robin arbitration with grant held for the full transaction.
- Bus timeout watchdog: a hung slave cannot lock the fabric.
- Sits between the masters and the slave-side decoder.

Parameters:
- N_MASTERS, 2, number of requesting masters (2..8).
- TIMEOUT, 64, max cycles in BUSY before forced error completion (≥2).
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- m_req  in  N_MASTERS  per-master request; must hold stable with its fields until its m_done.
- m_ttype  in  N_MASTERS x ttype_t  per-master READ/WRITE.
- m_addr  in  N_MASTERS x 32  per-master address.
- m_wdata  in  N_MASTERS x 32  per-master write data.
- m_rdata  out  32  read data, shared by all masters; valid only with that master's m_done.
- m_done  out  N_MASTERS  one-cycle completion pulse to the granted master.
- m_err  out  1  qualifies m_done: the completion was a timeout.
- s_ss  out  1  slave select to downstream.
- s_ttype  out  ttype_t  downstream transfer type.
- s_addr  out  32  downstream address.
- s_wdata  out  32  downstream write data.
- s_rdata  in  32  downstream read data.
- s_bdone  in  1  downstream completion; may be combinationally 1.
- grant_id  out  $clog2(N_MASTERS)  current or last granted master, for debug.

Behaviour:
- Reset values: state IDLE, grant_id 0, last_grant N_MASTERS-1 (master 0 wins first), timer 0. All outputs 0: s_ss, s_ttype=READ, s_addr, s_wdata, m_done, m_err, m_rdata.
- FSM states: IDLE, BUSY.
- IDLE, no m_req bit set:
  - Stay in IDLE.
  - s_ss=0; downstream fields hold the last granted master's values.
- IDLE, any m_req bit set:
  - Search from last_grant+1 upward, wrapping modulo N_MASTERS.
  - Register the first requester into grant_id.
  - Go to BUSY; timer cleared.
  - Arbitration latency: 1 cycle.
- BUSY:
  - s_ss=1.
  - s_ttype/s_addr/s_wdata are combinationally muxed from master grant_id.
  - Timer increments each cycle.
- BUSY with s_bdone=1 (same cycle, combinational):
  - m_done[grant_id]=1; m_rdata=s_rdata; m_err=0.
  - Next cycle: last_grant←grant_id, state IDLE.
- BUSY with s_bdone=0 and timer==TIMEOUT-1:
  - s_ss stays 1.
  - m_done[grant_id]=1; m_rdata=ERR_DATA; m_err=1; go to IDLE.
  - Timeout: exactly TIMEOUT cycles in BUSY without s_bdone.
- Simultaneous s_bdone and timeout in the same cycle: s_bdone wins, m_err=0.
- Throughput:
  - With a 1-cycle slave, one transaction per 2 cycles (IDLE, BUSY).
  - The mandatory IDLE cycle is where round-robin re-evaluates.
- Granted master drops m_req during BUSY:
  - Transaction completes normally; m_done is still pulsed.
  - Protocol violation; not an error.
- All N requesting continuously: grants rotate 0,1,..,N-1,0. Worst-case wait is (N-1) transactions.
- m_done is never asserted for a non-granted master. At most one m_done bit is high per cycle.
- Reset asserted mid-BUSY:
  - Immediate return to reset values; s_ss drops asynchronously.
  - No m_done is generated for the aborted transaction.
- Timer is wide enough for TIMEOUT: $clog2(TIMEOUT+1) bits, no wrap in BUSY.

Decomposition:
- bus_if_types_pkg holds:
  - existing ttype_t (READ/WRITE);
  - new arb_state_t enum {IDLE, BUSY};
  - BUS_ERR_DATA constant.
- One natural sub-module: rr_pick. Combinational, params N; inputs req[N] and last[$clog2(N)]; outputs any, idx.
- Reusable by future interrupt-controller priority logic.

Test Plan:
- Reset release, m_req=2'b01, master 0 WRITE addr 0x0C wdata 0xA5, s_bdone tied 1:
  - s_ss high on cycle 2, s_addr=0x0C, s_wdata=0xA5;
  - m_done=2'b01 that cycle, m_err=0.
- Both masters request continuously, s_bdone=1 for 8 transactions: grant_id sequence 0,1,0,1,0,1,0,1; each m_done one cycle wide.
- Master 1 READ addr 0x00, s_rdata=0x0000_003C: m_rdata=0x3C with m_done=2'b10; m_done[0] stays 0 throughout.
- s_bdone held 0, TIMEOUT=64, master 0 READ:
  - m_done[0] after exactly 64 BUSY cycles, m_err=1, m_rdata=0xDEAD_BEEF;
  - state IDLE next cycle.
- s_bdone asserted on the same cycle as timer==TIMEOUT-1: m_err=0, m_rdata=s_rdata.
- rst_n pulsed low during BUSY with s_bdone=0:
  - s_ss=0 immediately, no m_done pulse;
  - after release with both requesting, master 0 granted first.
